// File: rtl/cam_sccb_init_sequencer_if.sv
// Bundles the table ROM, SCCB pad and camera control signals of the camera
// init sequencer.
//   master : the sequencer (drives rom_addr, SCCB pads, camera controls, status)
//   slave  : the surroundings (table ROM, SIOD pad sample, start request)
// ROM_AW must match the ROM_AW of the sequencer it is connected to.
interface cam_sccb_init_sequencer_if #(
    parameter int unsigned ROM_AW = 8
);
    logic              start;      // single-cycle re-run request
    logic [ROM_AW-1:0] rom_addr;   // table address
    logic [15:0]       rom_data;   // {reg, val}, one cycle after rom_addr
    logic              sioc;       // SCCB clock, push-pull
    logic              siod_oe;    // 1 = pull SIOD low
    logic              siod_in;    // SIOD pad sample
    logic              cam_rst_n;  // camera reset, active low
    logic              cam_pwdn;   // camera power-down, active high
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, rom_data, siod_in,
        output rom_addr, sioc, siod_oe, cam_rst_n, cam_pwdn, busy, done, err
    );

    modport slave (
        output start, rom_data, siod_in,
        input  rom_addr, sioc, siod_oe, cam_rst_n, cam_pwdn, busy, done, err
    );
endinterface

// File: rtl/cam_sccb_init_sequencer.sv
// Camera power-up and SCCB register configuration sequencer.
// After reset it holds the camera in reset, waits for power to settle, then
// walks a (reg, val) table in an external synchronous ROM and writes each
// entry as a 3-phase SCCB write (SLAVE_ID, reg, val). 16'hFFF0 entries insert
// a delay, 16'hFFFF ends the table and raises done.
// Ports:
//   clk_27_i  system clock
//   reset_i   asynchronous active-high reset
//   ctrl_io   master modport: start, rom_addr/rom_data, sioc/siod_oe/siod_in,
//             cam_rst_n, cam_pwdn, busy, done, err
// Optional feature: define SCCB_ACK_CHECK_EN to sample the 9th (ACK) bit;
// a NACK aborts the write with a STOP and retries the entry, and a third NACK
// enters an error state. Without it err is tied low and siod_in is unused.
module cam_sccb_init_sequencer #(
    parameter logic [7:0]  SLAVE_ID   = 8'h42,
    parameter int unsigned CLK_DIV    = 67,
    parameter int unsigned RST_CYCLES = 27000,
    parameter int unsigned PWR_WAIT   = 27000,
    parameter int unsigned DLY_CYCLES = 270000,
    parameter int unsigned ROM_AW     = 8
) (
    input logic                       clk_27_i,
    input logic                       reset_i,
    cam_sccb_init_sequencer_if.master ctrl_io
);

    typedef enum logic [3:0] {
        StCamRst, StPwrWait, StFetchAddr, StFetchData, StDelay,
        StStart, StBit, StStop, StGap, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       div_q, div_d;
    logic [1:0]        sub_q, sub_d;    // tick step inside START/STOP/GAP, quarter in a bit
    logic [3:0]        bit_q, bit_d;    // 0..7 data bits, 8 = ACK slot
    logic [1:0]        byte_q, byte_d;  // 0 = ID, 1 = reg, 2 = val
    logic [7:0]        reg_q, reg_d, val_q, val_d;
    logic              sioc_q, sioc_d, oe_q, oe_d;
    logic              rst_n_q, rst_n_d, pwdn_q, pwdn_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
`ifdef SCCB_ACK_CHECK_EN
    logic              err_q, err_d, nack_q, nack_d;
    logic [1:0]        att_q, att_d;    // NACKed attempts of the current entry
`endif

    logic       tick;
    logic [7:0] cur_byte;
    logic       bit_val;

    // Free-running divider; SCCB phases only move on its tick.
    assign tick  = (div_q == CLK_DIV - 1);
    assign div_d = tick ? 32'd0 : div_q + 32'd1;

    always_comb begin
        cur_byte = val_q;
        unique case (byte_q)
            2'd0:    cur_byte = SLAVE_ID;
            2'd1:    cur_byte = reg_q;
            default: cur_byte = val_q;
        endcase
        // ACK slot sends a 1, i.e. SIOD released
        bit_val = (bit_q == 4'd8) ? 1'b1 : cur_byte[3'd7 - bit_q[2:0]];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        reg_d   = reg_q;
        val_d   = val_q;
        sioc_d  = sioc_q;
        oe_d    = oe_q;
        rst_n_d = rst_n_q;
        pwdn_d  = pwdn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        addr_d  = addr_q;
`ifdef SCCB_ACK_CHECK_EN
        err_d   = err_q;
        nack_d  = nack_q;
        att_d   = att_q;
`endif
        case (state_q)
            StCamRst: begin
                pwdn_d = 1'b0;
                busy_d = 1'b1;
                if (cnt_q == RST_CYCLES - 1) begin
                    rst_n_d = 1'b1;
                    cnt_d   = 32'd0;
                    state_d = StPwrWait;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StPwrWait: begin
                if (cnt_q == PWR_WAIT - 1) begin
                    cnt_d   = 32'd0;
                    state_d = StFetchAddr;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // rom_addr is already stable; the ROM registers its output this cycle
            StFetchAddr: state_d = StFetchData;
            StFetchData: begin
                if (ctrl_io.rom_data == 16'hFFFF) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else if (ctrl_io.rom_data == 16'hFFF0) begin
                    cnt_d   = 32'd0;
                    state_d = StDelay;
                end else begin
                    reg_d   = ctrl_io.rom_data[15:8];
                    val_d   = ctrl_io.rom_data[7:0];
                    sub_d   = 2'd0;
                    state_d = StStart;
                end
            end
            StDelay: begin
                if (cnt_q == DLY_CYCLES - 1) begin
                    cnt_d   = 32'd0;
                    addr_d  = addr_q + 1'b1;
                    state_d = StFetchAddr;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StStart: begin
                if (tick) begin
                    if (sub_q == 2'd0) begin
                        oe_d  = 1'b1;  // SIOD falls with SIOC high
                        sub_d = 2'd1;
                    end else begin
                        sioc_d  = 1'b0;
                        sub_d   = 2'd0;
                        bit_d   = 4'd0;
                        byte_d  = 2'd0;
                        state_d = StBit;
                    end
                end
            end
            StBit: begin
                if (tick) begin
                    sub_d = sub_q + 2'd1;
                    case (sub_q)
                        2'd0: begin
                            sioc_d = 1'b0;
                            oe_d   = ~bit_val;
                        end
                        2'd2: sioc_d = 1'b1;
                        2'd3: begin
                            if (bit_q == 4'd8) begin
                                bit_d = 4'd0;
                                if (byte_q == 2'd2) begin
                                    state_d = StStop;
                                end else begin
                                    byte_d = byte_q + 2'd1;
                                end
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
`ifdef SCCB_ACK_CHECK_EN
                            if (bit_q == 4'd8 && ctrl_io.siod_in) begin
                                nack_d  = 1'b1;
                                state_d = StStop;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            StStop: begin
                if (tick) begin
                    case (sub_q)
                        2'd0: begin
                            sioc_d = 1'b0;
                            oe_d   = 1'b1;
                            sub_d  = 2'd1;
                        end
                        2'd1: begin
                            sioc_d = 1'b1;
                            sub_d  = 2'd2;
                        end
                        default: begin
                            oe_d    = 1'b0;  // SIOD rises with SIOC high
                            sub_d   = 2'd0;
                            addr_d  = addr_q + 1'b1;
                            state_d = StGap;
`ifdef SCCB_ACK_CHECK_EN
                            att_d = 2'd0;
                            if (nack_q) begin
                                nack_d = 1'b0;
                                addr_d = addr_q;  // retry the same entry
                                if (att_q == 2'd2) begin
                                    busy_d  = 1'b0;
                                    err_d   = 1'b1;
                                    state_d = StError;
                                end else begin
                                    att_d = att_q + 2'd1;
                                end
                            end
`endif
                        end
                    endcase
                end
            end
            StGap: begin
                if (tick) begin
                    sub_d = sub_q + 2'd1;
                    if (sub_q == 2'd3) begin
                        state_d = StFetchAddr;
                    end
                end
            end
            StDone: begin
                if (ctrl_io.start) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    state_d = StFetchAddr;
                end
            end
`ifdef SCCB_ACK_CHECK_EN
            StError: begin
                if (ctrl_io.start) begin
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    att_d   = 2'd0;
                    addr_d  = '0;
                    state_d = StFetchAddr;
                end
            end
`endif
            default: state_d = StCamRst;
        endcase
    end

    always_ff @(posedge clk_27_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StCamRst;
            cnt_q   <= 32'd0;
            div_q   <= 32'd0;
            sub_q   <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            reg_q   <= 8'd0;
            val_q   <= 8'd0;
            sioc_q  <= 1'b1;
            oe_q    <= 1'b0;
            rst_n_q <= 1'b0;
            pwdn_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
`ifdef SCCB_ACK_CHECK_EN
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
            att_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            sioc_q  <= sioc_d;
            oe_q    <= oe_d;
            rst_n_q <= rst_n_d;
            pwdn_q  <= pwdn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
`ifdef SCCB_ACK_CHECK_EN
            err_q   <= err_d;
            nack_q  <= nack_d;
            att_q   <= att_d;
`endif
        end
    end

    assign ctrl_io.rom_addr  = addr_q;
    assign ctrl_io.sioc      = sioc_q;
    assign ctrl_io.siod_oe   = oe_q;
    assign ctrl_io.cam_rst_n = rst_n_q;
    assign ctrl_io.cam_pwdn  = pwdn_q;
    assign ctrl_io.busy      = busy_q;
    assign ctrl_io.done      = done_q;
`ifdef SCCB_ACK_CHECK_EN
    assign ctrl_io.err       = err_q;
`else
    assign ctrl_io.err       = 1'b0;
`endif

endmodule

// File: tb/tb_cam_sccb_init_sequencer.sv
// Bench for cam_sccb_init_sequencer: decodes the SCCB bus from the pads and
// compares bytes, inter-transaction gaps and status against a table-level model.
module tb_cam_sccb_init_sequencer;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned RST_CYCLES = 10;
    localparam int unsigned PWR_WAIT   = 20;
    localparam int unsigned DLY_CYCLES = 50;
    localparam int unsigned ROM_AW     = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cam_sccb_init_sequencer_if #(.ROM_AW(ROM_AW)) bus ();

    cam_sccb_init_sequencer #(
        .SLAVE_ID  (8'h42),
        .CLK_DIV   (CLK_DIV),
        .RST_CYCLES(RST_CYCLES),
        .PWR_WAIT  (PWR_WAIT),
        .DLY_CYCLES(DLY_CYCLES),
        .ROM_AW    (ROM_AW)
    ) dut (
        .clk_27_i(clk),
        .reset_i (reset),
        .ctrl_io (bus)
    );

    // synchronous table ROM
    logic [15:0] rom_mem [256];
    always_ff @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic [7:0] obs_q[$];
    int         gap_q[$];
    int         cyc = 0;
    int         stop_cyc = -1;
    int         n_start = 0;
    int         bad_ack = 0;
    bit         rstn_low_seen = 0;

    initial begin
        logic scl, sda, prev_scl, prev_sda, in_txn;
        logic [8:0] shreg;
        int bitcnt;
        prev_scl = 1'b1; prev_sda = 1'b1; in_txn = 1'b0; bitcnt = 0; shreg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            scl = bus.sioc;
            sda = ~bus.siod_oe;
            if (!reset && bus.cam_rst_n === 1'b0) rstn_low_seen = 1;
            if (reset) begin
                in_txn = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
            end else begin
                if (prev_scl && scl && prev_sda && !sda) begin
                    if (stop_cyc >= 0) gap_q.push_back(cyc - stop_cyc);
                    n_start++;
                    in_txn = 1'b1;
                    bitcnt = 0;
                end else if (prev_scl && scl && !prev_sda && sda) begin
                    in_txn = 1'b0;
                    stop_cyc = cyc;
                end else if (!prev_scl && scl && in_txn) begin
                    shreg = {shreg[7:0], sda};
                    bitcnt++;
                    if (bitcnt == 9) begin
                        obs_q.push_back(shreg[8:1]);
                        if (!sda) bad_ack++;
                        bitcnt = 0;
                    end
                end
                prev_scl = scl;
                prev_sda = sda;
            end
        end
    end

    task automatic clear_mon();
        obs_q.delete();
        gap_q.delete();
        stop_cyc = -1;
        n_start = 0;
        bad_ack = 0;
        rstn_low_seen = 0;
    endtask

    // ---------------- table-level reference model ----------------
    logic [15:0] tbl[$];
    logic [7:0]  exp_bytes[$];
    int          exp_dly[$];
    int          exp_end;

    task automatic load_and_model();
        int pending;
        bit seen;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        foreach (tbl[i]) rom_mem[i] = tbl[i];
        exp_bytes.delete();
        exp_dly.delete();
        pending = 0;
        seen = 0;
        exp_end = tbl.size() - 1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i] == 16'hFFFF) begin
                exp_end = i;
                break;
            end
            if (tbl[i] == 16'hFFF0) begin
                pending++;
            end else begin
                if (seen) exp_dly.push_back(pending);
                pending = 0;
                seen = 1;
                exp_bytes.push_back(8'h42);
                exp_bytes.push_back(tbl[i][15:8]);
                exp_bytes.push_back(tbl[i][7:0]);
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done || bus.err) begin
                ok = 1;
                break;
            end
        end
        check_eq({tag, ".finished"}, 32'(ok), 32'd1);
    endtask

    task automatic check_run(input string tag);
        int lim;
        check_eq({tag, ".nbytes"}, obs_q.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < obs_q.size(); i++)
            check_eq({tag, ".byte"}, 32'(obs_q[i]), 32'(exp_bytes[i]));
        check_eq({tag, ".ngaps"}, gap_q.size(), exp_dly.size());
        for (int i = 0; i < exp_dly.size() && i < gap_q.size(); i++) begin
            lim = (exp_dly[i] == 0) ? 1 : exp_dly[i] * int'(DLY_CYCLES);
            check_eq({tag, ".gap_ok"}, (gap_q[i] >= lim) ? 32'd1 : 32'd0, 32'd1);
        end
        check_eq({tag, ".ack_released"}, bad_ack, 0);
        check_eq({tag, ".done"}, 32'(bus.done), 32'd1);
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ".err"}, 32'(bus.err), 32'd0);
        check_eq({tag, ".rom_addr"}, 32'(bus.rom_addr), exp_end);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic count_rst_low(input string tag);
        int n;
        n = 1;
        @(negedge clk);
        while (!bus.cam_rst_n && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".rst_cycles"}, n, RST_CYCLES);
    endtask

`ifndef SCCB_ACK_CHECK_EN
    // siod_in must have no effect in the default build
    initial forever @(negedge clk) bus.siod_in = 1'($urandom);
`endif

    initial begin
        int m, n;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        bus.start = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        bus.siod_in = 1'b0;
`endif
        // ---- reset state and power-up ----
        tbl = {16'h1280, 16'hFFFF};
        load_and_model();
        repeat (3) @(negedge clk);
        check_eq("rst.sioc", 32'(bus.sioc), 32'd1);
        check_eq("rst.siod_oe", 32'(bus.siod_oe), 32'd0);
        check_eq("rst.cam_rst_n", 32'(bus.cam_rst_n), 32'd0);
        check_eq("rst.cam_pwdn", 32'(bus.cam_pwdn), 32'd1);
        check_eq("rst.busy", 32'(bus.busy), 32'd0);
        check_eq("rst.done", 32'(bus.done), 32'd0);
        check_eq("rst.err", 32'(bus.err), 32'd0);
        check_eq("rst.rom_addr", 32'(bus.rom_addr), 32'd0);
        clear_mon();
        reset = 1'b0;
        count_rst_low("pwr");
        check_eq("pwr.cam_pwdn", 32'(bus.cam_pwdn), 32'd0);
        check_eq("pwr.busy", 32'(bus.busy), 32'd1);
        m = 0;
        while (!bus.siod_oe && m < 1000) begin
            @(negedge clk);
            m++;
        end
        check_eq("pwr.first_start_ok",
                 (m >= int'(PWR_WAIT) + 3 && m <= int'(PWR_WAIT + 2 + CLK_DIV)) ? 32'd1 : 32'd0,
                 32'd1);
        check_eq("pwr.start_scl_high", 32'(bus.sioc), 32'd1);
        wait_done("t1", 5000);
        check_run("t1");

        // ---- delay entry, restart from DONE, start ignored while busy ----
        tbl = {16'h1101, 16'hFFF0, 16'h6B4A, 16'hFFFF};
        load_and_model();
        clear_mon();
        pulse_start();
        check_eq("t2.rom_addr0", 32'(bus.rom_addr), 32'd0);
        check_eq("t2.busy", 32'(bus.busy), 32'd1);
        check_eq("t2.done", 32'(bus.done), 32'd0);
        repeat (40) @(negedge clk);
        pulse_start();
        wait_done("t2", 5000);
        check_run("t2");
        check_eq("t2.no_cam_reset", 32'(rstn_low_seen), 32'd0);

        // ---- replay identical table ----
        clear_mon();
        pulse_start();
        wait_done("t3", 5000);
        check_run("t3");
        check_eq("t3.no_cam_reset", 32'(rstn_low_seen), 32'd0);

        // ---- random tables ----
        for (int it = 0; it < 4; it++) begin
            int n;
            tbl.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) tbl.push_back(16'hFFF0);
                else tbl.push_back({8'($urandom_range(0, 254)), 8'($urandom)});
            end
            tbl.push_back(16'hFFFF);
            load_and_model();
            clear_mon();
            pulse_start();
            wait_done("rnd", 8000);
            check_run("rnd");
        end

        // ---- reset mid-byte of the second transaction ----
        tbl = {16'h3A5C, 16'h71E2, 16'hFFFF};
        load_and_model();
        clear_mon();
        pulse_start();
        m = 0;
        while (obs_q.size() < 4 && m < 5000) begin
            @(negedge clk);
            m++;
        end
        check_eq("mid.reached", (obs_q.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mid.sioc", 32'(bus.sioc), 32'd1);
        check_eq("mid.siod_oe", 32'(bus.siod_oe), 32'd0);
        check_eq("mid.cam_rst_n", 32'(bus.cam_rst_n), 32'd0);
        check_eq("mid.busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        clear_mon();
        reset = 1'b0;
        count_rst_low("mid");
        wait_done("mid", 8000);
        check_run("mid");

`ifdef SCCB_ACK_CHECK_EN
        // ---- NACK retries then error ----
        tbl = {16'h1280, 16'hFFFF};
        load_and_model();
        clear_mon();
        bus.siod_in = 1'b1;
        pulse_start();
        wait_done("nack", 8000);
        check_eq("nack.attempts", n_start, 3);
        check_eq("nack.err", 32'(bus.err), 32'd1);
        check_eq("nack.busy", 32'(bus.busy), 32'd0);
        check_eq("nack.done", 32'(bus.done), 32'd0);
        bus.siod_in = 1'b0;
        clear_mon();
        pulse_start();
        check_eq("nack.err_cleared", 32'(bus.err), 32'd0);
        check_eq("nack.rom_addr0", 32'(bus.rom_addr), 32'd0);
        wait_done("nack_rerun", 5000);
        check_run("nack_rerun");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
